spi_burst_writer: RTL and testbench

- SPI-slave front end for the framebuffer SRAM path, parametrised for address width, pixel width and queue depth.
- Adds a command/address header, an auto-increment burst mode and a write FIFO, so pixel data decouples from the display-fetch arbiter.
- Sits between the external SPI pins and the memory arbiter inside the vga top level.
- The arbiter grants SRAM write slots during fetch gaps.

---
 rtl/spi_burst_writer.sv | 219 +++++++++++++++++++++
 tb/tb_spi_burst_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_writer.sv
// SPI-slave burst writer: command/address header, auto-increment bursts and a
// first-word fall-through write queue feeding the SRAM write arbiter.
module spi_burst_writer #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int ADDR_BYTES  = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          MainClk,
  input  logic                          Reset,
  input  logic                          Sclk,
  input  logic                          Mosi,
  input  logic                          CSel,
  output logic                          MemWrReq,
  input  logic                          MemWrGrant,
  output logic [ADDR_W-1:0]             MemWrAddr,
  output logic [DATA_W-1:0]             MemWrData,
  output logic                          Busy,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int ENTRY_W    = ADDR_W + DATA_W;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} RxState;

  RxState state, stateNext;

  logic [SYNC_STAGES-1:0] sclkSync, mosiSync, cselSync;
  logic sclkS, mosiS, cselS;
  logic sclkPrev, cselPrev;
  logic sclkRise, cselFall;

  logic [2:0]       bitCnt;
  logic [6:0]       bitShift;
  logic             byteValid;
  logic [7:0]       byteData;

  logic [CNT_W-1:0]  byteCnt, byteCntNext;
  logic              burstMode, burstNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [DATA_W-1:0] wordNext;
  logic              pushReq;

  logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [LVL_W-1:0]   level;
  logic               fifoEmpty, fifoFull, pop, pushOk, drop;
  logic [ENTRY_W-1:0] headEntry;

  // CSel chain resets to "selected" so a frame already in flight at reset can
  // never produce a falling edge; the receiver waits for CSel to be seen high.
  always_ff @(posedge MainClk) begin
    if (Reset) begin
      sclkSync <= '0;
      mosiSync <= '0;
      cselSync <= '0;
      sclkPrev <= 1'b0;
      cselPrev <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], Sclk};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], Mosi};
      cselSync <= {cselSync[SYNC_STAGES-2:0], CSel};
      sclkPrev <= sclkS;
      cselPrev <= cselS;
    end
  end

  assign sclkS    = sclkSync[SYNC_STAGES-1];
  assign mosiS    = mosiSync[SYNC_STAGES-1];
  assign cselS    = cselSync[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev;
  assign cselFall = cselPrev & ~cselS;

  always_ff @(posedge MainClk) begin
    if (Reset) begin
      bitCnt   <= '0;
      bitShift <= '0;
    end else if (cselS) begin
      bitCnt <= '0;
    end else if (sclkRise && state != IDLE) begin
      bitCnt   <= bitCnt + 3'd1;
      bitShift <= {bitShift[5:0], mosiS};
    end
  end

  // The completed byte is consumed combinationally to keep push latency short.
  assign byteValid = sclkRise && !cselS && (state != IDLE) && (bitCnt == 3'd7);
  assign byteData  = {bitShift, mosiS};

  always_ff @(posedge MainClk) begin
    if (Reset) begin
      state     <= IDLE;
      byteCnt   <= '0;
      burstMode <= 1'b0;
      addrReg   <= '0;
    end else begin
      state     <= stateNext;
      byteCnt   <= byteCntNext;
      burstMode <= burstNext;
      addrReg   <= addrNext;
    end
  end

  always_comb begin
    stateNext   = state;
    byteCntNext = byteCnt;
    burstNext   = burstMode;
    addrNext    = addrReg;
    pushReq     = 1'b0;
    if (cselS) begin
      stateNext   = IDLE;
      byteCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cselFall) begin
            stateNext   = CMD;
            byteCntNext = '0;
          end
        end
        CMD: begin
          if (byteValid) begin
            if (byteData == 8'h00) begin
              burstNext = 1'b0;
              stateNext = ADDR;
            end else if (byteData == 8'h01) begin
              burstNext = 1'b1;
              stateNext = ADDR;
            end else begin
              stateNext = IGNORE;
            end
          end
        end
        ADDR: begin
          // Shifting MSB first leaves only the low ADDR_W bits after the header.
          if (byteValid) begin
            addrNext = (addrReg << 8) | ADDR_W'(byteData);
            if (byteCnt == CNT_W'(ADDR_BYTES - 1)) begin
              byteCntNext = '0;
              stateNext   = DATA;
            end else begin
              byteCntNext = byteCnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (byteValid) begin
            if (byteCnt == CNT_W'(WORD_BYTES - 1)) begin
              byteCntNext = '0;
              pushReq     = 1'b1;
              if (burstMode) addrNext = addrReg + ADDR_W'(1);
            end else begin
              byteCntNext = byteCnt + CNT_W'(1);
            end
          end
        end
        IGNORE: begin
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  if (WORD_BYTES == 1) begin : gSingleByte
    assign wordNext = byteData;
  end else begin : gMultiByte
    logic [DATA_W-9:0] wordShift;

    always_ff @(posedge MainClk) begin
      if (Reset) wordShift <= '0;
      else if (byteValid && state == DATA) wordShift <= wordNext[DATA_W-9:0];
    end

    assign wordNext = {wordShift, byteData};
  end

  // A push into a full queue survives only when the head leaves in the same cycle.
  assign fifoEmpty = (level == '0);
  assign fifoFull  = (level == LVL_W'(FIFO_DEPTH));
  assign pop       = !fifoEmpty && MemWrGrant;
  assign pushOk    = pushReq && (!fifoFull || pop);
  assign drop      = pushReq && !pushOk;

  always_ff @(posedge MainClk) begin
    if (pushOk) fifoMem[wrPtr] <= {addrReg, wordNext};
  end

  always_ff @(posedge MainClk) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)    rdPtr <= rdPtr + PTR_W'(1);
      case ({pushOk, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) Overflow <= 1'b1;
    end
  end

  assign headEntry = fifoMem[rdPtr];
  assign MemWrReq  = !fifoEmpty;
  assign MemWrAddr = fifoEmpty ? '0 : headEntry[ENTRY_W-1:DATA_W];
  assign MemWrData = fifoEmpty ? '0 : headEntry[DATA_W-1:0];
  assign FifoLevel = level;
  assign Busy      = (state != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_spi_burst_writer.sv
// Directed bench for spi_burst_writer: default, shallow-queue and 16-bit-word
// instances share the SPI lines; each has its own chip select and grant.
module tb_spi_burst_writer;

  logic MainClk = 1'b0;
  logic Reset   = 1'b1;
  logic Sclk    = 1'b0;
  logic Mosi    = 1'b0;
  logic [2:0] cselVec = 3'b111;
  logic [2:0] grant   = 3'b111;

  logic        reqA, busyA, ovfA;
  logic [18:0] addrA;
  logic [7:0]  dataA;
  logic [4:0]  levelA;
  logic        reqB, busyB, ovfB;
  logic [18:0] addrB;
  logic [7:0]  dataB;
  logic [2:0]  levelB;
  logic        reqC, busyC, ovfC;
  logic [18:0] addrC;
  logic [15:0] dataC;
  logic [4:0]  levelC;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [18:0] qAddrA[$], qAddrB[$], qAddrC[$];
  logic [15:0] qDataA[$], qDataB[$], qDataC[$];

  typedef struct {
    logic [7:0]       cmd;
    logic [23:0]      addr;
    int               nData;
    logic [3:0][7:0]  data;
    int               expN;
    logic [3:0][18:0] expAddr;
    logic [3:0][7:0]  expData;
  } vec_t;

  vec_t vecs[5];

  always #5 MainClk = ~MainClk;

  spi_burst_writer dutA (
    .MainClk(MainClk), .Reset(Reset), .Sclk(Sclk), .Mosi(Mosi), .CSel(cselVec[0]),
    .MemWrReq(reqA), .MemWrGrant(grant[0]), .MemWrAddr(addrA), .MemWrData(dataA),
    .Busy(busyA), .Overflow(ovfA), .FifoLevel(levelA));

  spi_burst_writer #(.FIFO_DEPTH(4)) dutB (
    .MainClk(MainClk), .Reset(Reset), .Sclk(Sclk), .Mosi(Mosi), .CSel(cselVec[1]),
    .MemWrReq(reqB), .MemWrGrant(grant[1]), .MemWrAddr(addrB), .MemWrData(dataB),
    .Busy(busyB), .Overflow(ovfB), .FifoLevel(levelB));

  spi_burst_writer #(.DATA_W(16)) dutC (
    .MainClk(MainClk), .Reset(Reset), .Sclk(Sclk), .Mosi(Mosi), .CSel(cselVec[2]),
    .MemWrReq(reqC), .MemWrGrant(grant[2]), .MemWrAddr(addrC), .MemWrData(dataC),
    .Busy(busyC), .Overflow(ovfC), .FifoLevel(levelC));

  // Log every accepted write; grants only change just after a rising edge.
  always @(negedge MainClk) begin
    if (!Reset && reqA && grant[0]) begin qAddrA.push_back(addrA); qDataA.push_back(16'(dataA)); end
    if (!Reset && reqB && grant[1]) begin qAddrB.push_back(addrB); qDataB.push_back(16'(dataB)); end
    if (!Reset && reqC && grant[2]) begin qAddrC.push_back(addrC); qDataC.push_back(dataC); end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic spiBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      Mosi = b[7-i];
      #20 Sclk = 1'b1;
      #40 Sclk = 1'b0;
      #20;
    end
  endtask

  task automatic spiByte(input logic [7:0] b);
    spiBits(b, 8);
  endtask

  task automatic frameBegin(input int t);
    cselVec[t] = 1'b0;
    #60;
  endtask

  task automatic frameEnd();
    #40 cselVec = 3'b111;
    #300;
  endtask

  task automatic applyStimulus(input vec_t v);
    frameBegin(0);
    spiByte(v.cmd);
    spiByte(v.addr[23:16]);
    spiByte(v.addr[15:8]);
    spiByte(v.addr[7:0]);
    for (int i = 0; i < v.nData; i++) spiByte(v.data[i]);
    frameEnd();
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      vecs[k].data = '0; vecs[k].expAddr = '0; vecs[k].expData = '0;
    end
    vecs[0].cmd = 8'h00; vecs[0].addr = 24'h000123; vecs[0].nData = 1;
    vecs[0].data[0] = 8'hC0;
    vecs[0].expN = 1; vecs[0].expAddr[0] = 19'h00123; vecs[0].expData[0] = 8'hC0;

    vecs[1].cmd = 8'h01; vecs[1].addr = 24'h07FFFF; vecs[1].nData = 3;
    vecs[1].data[0] = 8'hC0; vecs[1].data[1] = 8'h03; vecs[1].data[2] = 8'h0C;
    vecs[1].expN = 3;
    vecs[1].expAddr[0] = 19'h7FFFF; vecs[1].expData[0] = 8'hC0;
    vecs[1].expAddr[1] = 19'h00000; vecs[1].expData[1] = 8'h03;
    vecs[1].expAddr[2] = 19'h00001; vecs[1].expData[2] = 8'h0C;

    vecs[2].cmd = 8'h00; vecs[2].addr = 24'h000040; vecs[2].nData = 2;
    vecs[2].data[0] = 8'h11; vecs[2].data[1] = 8'h22;
    vecs[2].expN = 2;
    vecs[2].expAddr[0] = 19'h00040; vecs[2].expData[0] = 8'h11;
    vecs[2].expAddr[1] = 19'h00040; vecs[2].expData[1] = 8'h22;

    vecs[3].cmd = 8'h7E; vecs[3].addr = 24'h123456; vecs[3].nData = 2;
    vecs[3].data[0] = 8'h77; vecs[3].data[1] = 8'h88;
    vecs[3].expN = 0;

    vecs[4].cmd = 8'h01; vecs[4].addr = 24'hFF8001; vecs[4].nData = 2;
    vecs[4].data[0] = 8'hA5; vecs[4].data[1] = 8'h5A;
    vecs[4].expN = 2;
    vecs[4].expAddr[0] = 19'h78001; vecs[4].expData[0] = 8'hA5;
    vecs[4].expAddr[1] = 19'h78002; vecs[4].expData[1] = 8'h5A;

    repeat (5) @(posedge MainClk);
    #1 Reset = 1'b0;
    checkOutput("reset MemWrReq", 32'(reqA), 32'h0);
    checkOutput("reset MemWrAddr", 32'(addrA), 32'h0);
    checkOutput("reset MemWrData", 32'(dataA), 32'h0);
    checkOutput("reset Busy", 32'(busyA), 32'h0);
    checkOutput("reset Overflow", 32'(ovfA), 32'h0);
    checkOutput("reset FifoLevel", 32'(levelA), 32'h0);
    #100;

    for (int k = 0; k < 5; k++) begin
      qAddrA.delete(); qDataA.delete();
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec%0d count", k), 32'(qAddrA.size()), 32'(vecs[k].expN));
      for (int i = 0; i < vecs[k].expN; i++) begin
        if (i < qAddrA.size()) begin
          checkOutput($sformatf("vec%0d addr%0d", k, i), 32'(qAddrA[i]), 32'(vecs[k].expAddr[i]));
          checkOutput($sformatf("vec%0d data%0d", k, i), 32'(qDataA[i]), 32'(vecs[k].expData[i]));
        end
      end
      checkOutput($sformatf("vec%0d level", k), 32'(levelA), 32'h0);
      checkOutput($sformatf("vec%0d busy", k), 32'(busyA), 32'h0);
    end

    // Abort mid data byte, then a bad command watched while in progress
    qAddrA.delete(); qDataA.delete();
    frameBegin(0);
    spiByte(8'h00); spiByte(8'h00); spiByte(8'h02); spiByte(8'h00);
    spiBits(8'hFF, 5);
    frameEnd();
    checkOutput("abort count", 32'(qAddrA.size()), 32'h0);
    checkOutput("abort busy", 32'(busyA), 32'h0);
    frameBegin(0);
    spiByte(8'h7E); spiByte(8'h12); spiByte(8'h34);
    #40;
    checkOutput("badcmd busy in frame", 32'(busyA), 32'h1);
    spiByte(8'h56); spiByte(8'h78); spiByte(8'h9A);
    frameEnd();
    checkOutput("badcmd count", 32'(qAddrA.size()), 32'h0);
    checkOutput("badcmd busy after", 32'(busyA), 32'h0);

    // Backpressure on the 4-deep instance
    @(posedge MainClk); #1 grant[1] = 1'b0;
    qAddrB.delete(); qDataB.delete();
    frameBegin(1);
    spiByte(8'h01); spiByte(8'h00); spiByte(8'h00); spiByte(8'h10);
    for (int i = 1; i <= 6; i++) spiByte(8'(i));
    frameEnd();
    checkOutput("ovf level", 32'(levelB), 32'h4);
    checkOutput("ovf flag", 32'(ovfB), 32'h1);
    checkOutput("ovf busy", 32'(busyB), 32'h1);
    checkOutput("ovf req", 32'(reqB), 32'h1);
    checkOutput("ovf head addr", 32'(addrB), 32'h10);
    checkOutput("ovf head data", 32'(dataB), 32'h01);
    @(posedge MainClk); #1 grant[1] = 1'b1;
    repeat (20) @(posedge MainClk);
    #1;
    checkOutput("ovf drain count", 32'(qAddrB.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < qAddrB.size()) begin
        checkOutput($sformatf("ovf addr%0d", i), 32'(qAddrB[i]), 32'h10 + 32'(i));
        checkOutput($sformatf("ovf data%0d", i), 32'(qDataB[i]), 32'(i + 1));
      end
    end
    checkOutput("ovf level drained", 32'(levelB), 32'h0);
    checkOutput("ovf sticky", 32'(ovfB), 32'h1);

    // 16-bit words: trailing odd byte is discarded
    qAddrC.delete(); qDataC.delete();
    frameBegin(2);
    spiByte(8'h00); spiByte(8'h00); spiByte(8'h00); spiByte(8'h05);
    spiByte(8'hAB); spiByte(8'hCD); spiByte(8'hEF);
    frameEnd();
    checkOutput("w16 count", 32'(qAddrC.size()), 32'h1);
    if (qAddrC.size() > 0) begin
      checkOutput("w16 addr", 32'(qAddrC[0]), 32'h5);
      checkOutput("w16 data", 32'(qDataC[0]), 32'hABCD);
    end
    checkOutput("w16 level", 32'(levelC), 32'h0);
    checkOutput("w16 busy", 32'(busyC), 32'h0);
    checkOutput("w16 overflow", 32'(ovfC), 32'h0);

    // Reset in the middle of a burst with CSel held low
    qAddrA.delete(); qDataA.delete();
    frameBegin(0);
    spiByte(8'h01); spiByte(8'h00); spiByte(8'h03); spiByte(8'h00);
    spiByte(8'h11); spiByte(8'h22);
    #40;
    @(posedge MainClk); #1 Reset = 1'b1;
    repeat (2) @(posedge MainClk);
    #1 Reset = 1'b0;
    spiByte(8'h33); spiByte(8'h44);
    #100;
    checkOutput("rst count", 32'(qAddrA.size()), 32'h2);
    if (qAddrA.size() > 1) begin
      checkOutput("rst addr1", 32'(qAddrA[1]), 32'h301);
      checkOutput("rst data1", 32'(qDataA[1]), 32'h22);
    end
    checkOutput("rst req", 32'(reqA), 32'h0);
    checkOutput("rst addr", 32'(addrA), 32'h0);
    checkOutput("rst data", 32'(dataA), 32'h0);
    checkOutput("rst busy", 32'(busyA), 32'h0);
    checkOutput("rst overflow", 32'(ovfA), 32'h0);
    checkOutput("rst level", 32'(levelA), 32'h0);
    frameEnd();
    checkOutput("rst count after csel", 32'(qAddrA.size()), 32'h2);
    frameBegin(0);
    spiByte(8'h00); spiByte(8'h00); spiByte(8'h04); spiByte(8'h00);
    spiByte(8'h99);
    frameEnd();
    checkOutput("post-rst count", 32'(qAddrA.size()), 32'h3);
    if (qAddrA.size() > 2) begin
      checkOutput("post-rst addr", 32'(qAddrA[2]), 32'h400);
      checkOutput("post-rst data", 32'(qDataA[2]), 32'h99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
